// File: rtl/switch_matrix_scanner.sv
// Column-scanning reader for an N x N active-low switch matrix.
// Optional per-cell debounce enabled by defining SCANNER_DEBOUNCE_EN.
module switch_matrix_scanner #(
  parameter int N              = 5,
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [N-1:0]         rows_in,
  output logic [N-1:0]         cols_out,
  output logic [$clog2(N):0]   x,
  output logic [N*N-1:0]       cells,
  output logic                 frame_done,
  output logic                 changed
);

  localparam int XW = $clog2(N) + 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE
  } state_t;

  state_t         state, state_nxt;
  logic [SW-1:0]  settle, settle_nxt;
  logic [XW-1:0]  x_nxt;
  logic           sample;
  logic           last_col;
  logic           flag;
  logic           any_flip;
  logic [N*N-1:0] cells_nxt;

`ifdef SCANNER_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  logic [CW-1:0] cnt     [N*N];
  logic [CW-1:0] cnt_nxt [N*N];
`endif

  // Row r, column c lands at the same bit the LED driver uses.
  function automatic int pos(input int r, input int c);
    return (N - 1 - r) * N + c;
  endfunction

  assign last_col = (x == XW'(N - 1));

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle;
    x_nxt      = x;
    sample     = 1'b0;
    cols_out   = '0;
    unique case (state)
      IDLE: begin
        if (ena) begin
          state_nxt  = DRIVE;
          x_nxt      = '0;
          settle_nxt = '0;
        end
      end
      DRIVE: begin
        cols_out   = N'(1) << x;
        settle_nxt = settle + 1'b1;
        if (settle == SW'(SETTLE_CYCLES - 1))
          state_nxt = SAMPLE;
      end
      SAMPLE: begin
        cols_out   = N'(1) << x;
        sample     = 1'b1;
        state_nxt  = DRIVE;
        settle_nxt = '0;
        x_nxt      = last_col ? '0 : x + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    // Disable abandons the partial frame without touching cells.
    if (!ena) begin
      state_nxt  = IDLE;
      sample     = 1'b0;
      x_nxt      = '0;
      settle_nxt = '0;
    end
  end

  always_comb begin
    cells_nxt = cells;
    any_flip  = 1'b0;
`ifdef SCANNER_DEBOUNCE_EN
    cnt_nxt   = cnt;
`endif
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (sample && x == XW'(c)) begin
`ifdef SCANNER_DEBOUNCE_EN
          if (~rows_in[r] == cells[pos(r, c)]) begin
            cnt_nxt[pos(r, c)] = '0;
          end else if (cnt[pos(r, c)] == CW'(DEBOUNCE_SCANS - 1)) begin
            cells_nxt[pos(r, c)] = ~cells[pos(r, c)];
            cnt_nxt[pos(r, c)]   = '0;
            any_flip             = 1'b1;
          end else begin
            cnt_nxt[pos(r, c)] = cnt[pos(r, c)] + 1'b1;
          end
`else
          if (~rows_in[r] != cells[pos(r, c)]) begin
            cells_nxt[pos(r, c)] = ~rows_in[r];
            any_flip             = 1'b1;
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle     <= '0;
      x          <= '0;
      cells      <= '0;
      frame_done <= 1'b0;
      changed    <= 1'b0;
      flag       <= 1'b0;
`ifdef SCANNER_DEBOUNCE_EN
      cnt        <= '{default: '0};
`endif
    end else begin
      state      <= state_nxt;
      settle     <= settle_nxt;
      x          <= x_nxt;
      cells      <= cells_nxt;
      frame_done <= sample && last_col;
      changed    <= sample && last_col && (flag || any_flip);
      if (!ena || (sample && last_col))
        flag <= 1'b0;
      else if (any_flip)
        flag <= 1'b1;
`ifdef SCANNER_DEBOUNCE_EN
      cnt        <= cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_switch_matrix_scanner.sv
// Scoreboard bench for switch_matrix_scanner: a key matrix model
// feeds rows_in, expected frames are queued and popped at frame_done.
module tb_switch_matrix_scanner;

  localparam int N   = 5;
  localparam int SC  = 4;
  localparam int DB  = 3;
  localparam int KEY = 22;
`ifdef SCANNER_DEBOUNCE_EN
  localparam int EFF_DEB = DB;
`else
  localparam int EFF_DEB = 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           ena;
  logic [N-1:0]   rows_in;
  logic [N-1:0]   cols_out;
  logic [3:0]     x;
  logic [N*N-1:0] cells;
  logic           frame_done;
  logic           changed;

  logic [N*N-1:0] keys;

  typedef struct packed {
    logic [N*N-1:0] cells;
    logic           changed;
  } exp_t;

  exp_t           sb[$];
  logic [N*N-1:0] mc;
  int             mcnt [N*N];
  int             checks = 0;
  int             errors = 0;

  always #5 clk = ~clk;

  switch_matrix_scanner #(
    .N(N),
    .SETTLE_CYCLES(SC),
    .DEBOUNCE_SCANS(DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .rows_in(rows_in),
    .cols_out(cols_out),
    .x(x),
    .cells(cells),
    .frame_done(frame_done),
    .changed(changed)
  );

  // Physical matrix: a closed key pulls its row low while its column drives.
  always_comb begin
    rows_in = '1;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (cols_out[c] && keys[(N-1-r)*N+c])
          rows_in[r] = 1'b0;
  end

  task automatic model_frame(input logic [N*N-1:0] raw);
    exp_t e;
    e.changed = 1'b0;
    for (int i = 0; i < N*N; i++) begin
      if (raw[i] == mc[i]) begin
        mcnt[i] = 0;
      end else if (mcnt[i] + 1 >= EFF_DEB) begin
        mc[i]     = ~mc[i];
        mcnt[i]   = 0;
        e.changed = 1'b1;
      end else begin
        mcnt[i]++;
      end
    end
    e.cells = mc;
    sb.push_back(e);
  endtask

  task automatic model_clear();
    mc = '0;
    for (int i = 0; i < N*N; i++) mcnt[i] = 0;
    sb.delete();
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      checks++;
      if (!$onehot0(cols_out)) begin
        errors++;
        $display("FAIL onehot cols_out got %b", cols_out);
      end
      if (frame_done) begin
        ok = 1'b1;
      end else begin
        checks++;
        if (changed !== 1'b0) begin
          errors++;
          $display("FAIL stray_changed got %b want 0", changed);
        end
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL frame_timeout got no frame_done want pulse");
    end
  endtask

  task automatic wait_x(input int tgt);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge clk);
      if (x == 4'(tgt)) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_x got x=%0d want %0d", x, tgt);
    end
  endtask

  // Call at a frame start; keys are held for the whole frame.
  task automatic run_frame(input logic [N*N-1:0] k);
    exp_t e;
    bit   ok;
    keys = k;
    model_frame(k);
    wait_frame(ok);
    e = sb.pop_front();
    if (ok) begin
      checks++;
      if (cells !== e.cells) begin
        errors++;
        $display("FAIL frame_cells got %h want %h", cells, e.cells);
      end
      checks++;
      if (changed !== e.changed) begin
        errors++;
        $display("FAIL frame_changed got %b want %b", changed, e.changed);
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if ({cols_out, x, cells, frame_done, changed} !== '0) begin
      errors++;
      $display("FAIL %s cols=%b x=%0d cells=%h fd=%b ch=%b want all 0",
               tag, cols_out, x, cells, frame_done, changed);
    end
  endtask

  task automatic test_reset();
    keys = '0;
    rst  = 1'b1;
    ena  = 1'b0;
    model_clear();
    @(negedge clk);
    check_reset_vals("reset_c1");
    ena = 1'b1;
    @(negedge clk);
    check_reset_vals("reset_c2");
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cols_out !== 5'b00001 || x !== 4'd0) begin
      errors++;
      $display("FAIL start got cols=%b x=%0d want 00001 x=0", cols_out, x);
    end
  endtask

  task automatic test_scan();
    logic [N-1:0] ec;
    bit           efd;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      ec  = 5'(1 << ((k / (SC+1)) % N));
      efd = (k % (N*(SC+1)) == 0);
      checks++;
      if ({cols_out, frame_done, changed} !== {ec, efd, 1'b0}
          || cells !== '0) begin
        errors++;
        $display("FAIL scan k=%0d got cols=%b fd=%b ch=%b cells=%h want %b %b 0 0",
                 k, cols_out, frame_done, changed, cells, ec, efd);
      end
    end
  endtask

  task automatic test_press();
    logic [N*N-1:0] p;
    p = '0;
    p[KEY] = 1'b1;
    for (int f = 0; f < DB; f++) run_frame(p);
    checks++;
    if (cells[KEY] !== 1'b1) begin
      errors++;
      $display("FAIL press_bit got %b want 1", cells[KEY]);
    end
    for (int f = 0; f < DB; f++) run_frame('0);
    checks++;
    if (cells[KEY] !== 1'b0) begin
      errors++;
      $display("FAIL release_bit got %b want 0", cells[KEY]);
    end
  endtask

  task automatic test_bounce();
    logic [N*N-1:0] p;
    p = '0;
    p[KEY] = 1'b1;
    run_frame(p);
    run_frame(p);
    run_frame('0);
    run_frame('0);
  endtask

  task automatic test_disable_reset();
    logic [N*N-1:0] p;
    logic [N*N-1:0] held;
    p = '0;
    p[KEY] = 1'b1;
    for (int f = 0; f < EFF_DEB; f++) run_frame(p);
    held = cells;
    wait_x(3);
    ena = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (cols_out !== '0 || frame_done !== 1'b0 || changed !== 1'b0
          || cells !== mc) begin
        errors++;
        $display("FAIL disabled i=%0d cols=%b fd=%b ch=%b cells=%h want 0 0 0 %h",
                 i, cols_out, frame_done, changed, cells, mc);
      end
    end
    checks++;
    if (held !== mc) begin
      errors++;
      $display("FAIL held_cells got %h want %h", held, mc);
    end
    ena = 1'b1;
    @(negedge clk);
    checks++;
    if (cols_out !== 5'b00001 || x !== 4'd0) begin
      errors++;
      $display("FAIL restart got cols=%b x=%0d want 00001 x=0", cols_out, x);
    end
    wait_x(2);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_reset");
    rst  = 1'b0;
    keys = '0;
    model_clear();
    @(negedge clk);
    checks++;
    if (cols_out !== 5'b00001) begin
      errors++;
      $display("FAIL post_reset got cols=%b want 00001", cols_out);
    end
    for (int f = 0; f < EFF_DEB; f++) run_frame(p);
    run_frame('0);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_press();
    test_bounce();
    test_disable_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
